des_f_sbox: RTL and testbench

Downstream neighbour of the DES expansion stage. Takes the 48-bit expanded half-block and the 48-bit round subkey, XORs them, runs the eight DES S-boxes serially (one S-box per cycle, one shared ROM), then applies the P permutation to produce the 32-bit Feistel f-function result. Valid/ready handshakes on both sides allow a round controller to stall it.

---
 rtl/des_pkg.sv | 21 ++
 rtl/des_sbox_rom.sv | 57 +++++
 rtl/des_f_sbox.sv | 92 +++++++++
 tb/tb_des_f_sbox.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions for the serial S-box / P-permutation stage.
package des_pkg;

    localparam int DES_HALF_W = 32;
    localparam int DES_EXP_W  = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // P permutation with DES bit 1 at the MSB on both sides: out bit i = in bit P[i].
    function automatic logic [DES_HALF_W-1:0] p_perm(input logic [DES_HALF_W-1:0] s);
        return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// Combinational S1..S8 lookup; sel = box number minus one, addr6 = b1..b6.
module des_sbox_rom (
    input  logic [2:0] sel,
    input  logic [5:0] addr6,
    output logic [3:0] dout
);

    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] row_word;

    assign row = {addr6[5], addr6[0]};
    assign col = addr6[4:1];

    // Each constant is one table row, column 0 in the top nibble.
    always_comb begin
        row_word = '0;
        case ({sel, row})
            5'b000_00: row_word = 64'hE4D12FB83A6C5907;
            5'b000_01: row_word = 64'h0F74E2D1A6CB9538;
            5'b000_10: row_word = 64'h41E8D62BFC973A50;
            5'b000_11: row_word = 64'hFC8249175B3EA06D;
            5'b001_00: row_word = 64'hF18E6B34972DC05A;
            5'b001_01: row_word = 64'h3D47F28EC01A69B5;
            5'b001_10: row_word = 64'h0E7BA4D158C6932F;
            5'b001_11: row_word = 64'hD8A13F42B67C05E9;
            5'b010_00: row_word = 64'hA09E63F51DC7B428;
            5'b010_01: row_word = 64'hD70934A6285ECBF1;
            5'b010_10: row_word = 64'hD6498F30B12C5AE7;
            5'b010_11: row_word = 64'h1AD069874FE3B52C;
            5'b011_00: row_word = 64'h7DE3069A1285BC4F;
            5'b011_01: row_word = 64'hD8B56F03472C1AE9;
            5'b011_10: row_word = 64'hA690CB7DF13E5284;
            5'b011_11: row_word = 64'h3F06A1D8945BC72E;
            5'b100_00: row_word = 64'h2C417AB6853FD0E9;
            5'b100_01: row_word = 64'hEB2C47D150FA3986;
            5'b100_10: row_word = 64'h421BAD78F9C5630E;
            5'b100_11: row_word = 64'hB8C71E2D6F09A453;
            5'b101_00: row_word = 64'hC1AF92680D34E75B;
            5'b101_01: row_word = 64'hAF427C9561DE0B38;
            5'b101_10: row_word = 64'h9EF528C3704A1DB6;
            5'b101_11: row_word = 64'h432C95FABE17608D;
            5'b110_00: row_word = 64'h4B2EF08D3C975A61;
            5'b110_01: row_word = 64'hD0B7491AE35C2F86;
            5'b110_10: row_word = 64'h14BDC37EAF680592;
            5'b110_11: row_word = 64'h6BD814A7950FE23C;
            5'b111_00: row_word = 64'hD2846FB1A93E50C7;
            5'b111_01: row_word = 64'h1FD8A374C56B0E92;
            5'b111_10: row_word = 64'h7B419CE206ADF358;
            5'b111_11: row_word = 64'h21E74A8DFC90356B;
            default:   row_word = '0;
        endcase
    end

    assign dout = row_word[{~col, 2'b00} +: 4];

endmodule

// File: rtl/des_f_sbox.sv
// DES f-function back end: key mix, eight serial S-box lookups through one ROM, then P.
module des_f_sbox
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DES_EXP_W-1:0]  e_in,
    input  logic [DES_EXP_W-1:0]  subkey,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DES_HALF_W-1:0] f_out,
    output logic                  busy
);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [DES_EXP_W-1:0]    x_q, x_d;
    logic [DES_HALF_W-1:0]   s_acc_q, s_acc_d;

    logic [DES_EXP_W-1:0]    x_shift;
    logic [3:0]              sbox_nib;
    logic [DES_HALF_W-1:0]   p_des;

    // Bring the current 6-bit group to the top instead of a variable part-select.
    assign x_shift = x_q << ({3'b000, cnt_q} * 6'd6);

    des_sbox_rom u_sbox_rom (
        .sel   (cnt_q),
        .addr6 (x_shift[DES_EXP_W-1 -: 6]),
        .dout  (sbox_nib)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        s_acc_d = s_acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = e_in ^ subkey;
                    cnt_d   = 3'd0;
                    s_acc_d = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                s_acc_d = {s_acc_q[DES_HALF_W-5:0], sbox_nib};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            x_q     <= '0;
            s_acc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            s_acc_q <= s_acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // Round logic wants DES bit 1 at f_out[0], so reverse the permuted word.
    assign p_des = p_perm(s_acc_q);

    generate
        for (genvar gi = 0; gi < DES_HALF_W; gi++) begin : g_rev
            assign f_out[gi] = p_des[DES_HALF_W-1-gi];
        end
    endgenerate

endmodule

// File: tb/tb_des_f_sbox.sv
// Directed checks of des_f_sbox against hand-computed FIPS 46-3 results.
module tb_des_f_sbox;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] e_in;
    logic [47:0] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_out;
    logic        busy;

    localparam logic [47:0] E_FIPS = 48'h7A15557A1555;
    localparam logic [47:0] K_FIPS = 48'h1B02EFFC7072;
    localparam logic [31:0] F_FIPS = 32'hDD9552C4;
    localparam logic [31:0] F_ZERO = 32'h3DDB1B1B;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] res_q[$];

    des_f_sbox dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_in      (e_in),
        .subkey    (subkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            res_q.push_back(f_out);
        end
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: accept, optional in_valid pulses during SUB, latency and result check.
    task automatic run_op(input string tag, input logic [47:0] e, input logic [47:0] k,
                          input logic [31:0] exp_f, input bit glitch);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 48'(in_ready), 48'd1);
        in_valid = 1'b1;
        e_in     = e;
        subkey   = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e_in     = '1;
        subkey   = '0;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (glitch) begin
                in_valid = (c <= 3);
                e_in     = ~e;
            end
            @(negedge clk);
            if (c == 3) check({tag, "_busy"}, 48'(busy), 48'd1);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 48'(lat), 48'd8);
        check({tag, "_f_out"}, 48'(f_out), 48'(exp_f));
        $display("op %s: f_out=%h expected=%h latency=%0d", tag, f_out, exp_f, lat);
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_ov_drop"}, 48'(out_valid), 48'd0);
            check({tag, "_idle"}, 48'(in_ready), 48'd1);
        end
    endtask

    initial begin
        int c0;
        int c1;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [47:0] same;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e_in      = '0;
        subkey    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 48'(in_ready), 48'd1);
        check("rst_out_valid", 48'(out_valid), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);

        run_op("fips", E_FIPS, K_FIPS, F_FIPS, 1'b0);
        run_op("swapped", K_FIPS, E_FIPS, F_FIPS, 1'b0);
        run_op("zero", 48'h0, 48'h0, F_ZERO, 1'b0);
        same = {$urandom(), $urandom()};
        run_op("equal_ops", same, same, F_ZERO, 1'b0);
        run_op("glitch", E_FIPS, K_FIPS, F_FIPS, 1'b1);

        // Backpressure: stall five cycles in DONE, then a single handshake.
        res_q.delete();
        out_ready = 1'b0;
        run_op("bp", E_FIPS, K_FIPS, F_FIPS, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_f", 48'(f_out), 48'(F_FIPS));
            check("bp_hold_in_ready", 48'(in_ready), 48'd0);
            check("bp_hold_busy", 48'(busy), 48'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 48'(in_ready), 48'd1);
        check("bp_release_out_valid", 48'(out_valid), 48'd0);
        check("bp_handshakes", 48'(res_q.size()), 48'd1);
        $display("backpressure: handshakes=%0d", res_q.size());

        // Back-to-back with in_valid held high.
        res_q.delete();
        c0 = -100;
        c1 = -1000;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        e_in     = E_FIPS;
        subkey   = K_FIPS;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                c0 = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        e_in   = 48'h0123456789AB;
        subkey = 48'h0123456789AB;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                c1 = cyc;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_spacing", 48'(c1 - c0), 48'd10);
        check("b2b_count", 48'(res_q.size()), 48'd2);
        r0 = (res_q.size() > 0) ? res_q[0] : 32'hxxxxxxxx;
        r1 = (res_q.size() > 1) ? res_q[1] : 32'hxxxxxxxx;
        check("b2b_first", 48'(r0), 48'(F_FIPS));
        check("b2b_second", 48'(r1), 48'(F_ZERO));
        $display("back_to_back: spacing=%0d results=%0d first=%h second=%h", c1 - c0, res_q.size(), r0, r1);

        // Reset on the fourth SUB cycle aborts the operation.
        res_q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        e_in     = E_FIPS;
        subkey   = K_FIPS;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 48'(out_valid), 48'd0);
        check("abort_in_ready", 48'(in_ready), 48'd1);
        check("abort_busy", 48'(busy), 48'd0);
        repeat (12) @(negedge clk);
        check("abort_no_result", 48'(res_q.size()), 48'd0);
        $display("abort: results after reset=%0d", res_q.size());
        run_op("post_rst", K_FIPS, E_FIPS, F_FIPS, 1'b0);
        check("post_rst_count", 48'(res_q.size()), 48'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
